// File: rtl/smvm_stream_tx_if.sv
// rtl/smvm_stream_tx_if.sv - host channels, core stream and status of the SMVM stream transmitter
interface smvm_stream_tx_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [11:0] hdr_rows;
    logic [11:0] hdr_cols;
    logic        vec_valid;
    logic        vec_ready;
    logic [7:0]  vec_data;
    logic        nz_valid;
    logic        nz_ready;
    logic [7:0]  nz_val;
    logic [11:0] nz_col;
    logic        nz_ipv;
    logic        nz_last;
    logic [7:0]  tx_val;
    logic        tx_ipv;
    logic [2:0]  tx_col;
    logic        tx_valid;
    logic        busy;
    logic        err_underrun;
    logic        err_col;

    modport master (
        output hdr_valid, hdr_rows, hdr_cols, vec_valid, vec_data,
               nz_valid, nz_val, nz_col, nz_ipv, nz_last,
        input  hdr_ready, vec_ready, nz_ready, tx_val, tx_ipv, tx_col,
               tx_valid, busy, err_underrun, err_col
    );

    modport slave (
        input  hdr_valid, hdr_rows, hdr_cols, vec_valid, vec_data,
               nz_valid, nz_val, nz_col, nz_ipv, nz_last,
        output hdr_ready, vec_ready, nz_ready, tx_val, tx_ipv, tx_col,
               tx_valid, busy, err_underrun, err_col
    );
endinterface

// File: rtl/smvm_stream_tx.sv
// rtl/smvm_stream_tx.sv - SMVM job serializer with ping-pong nonzero groups; SMVM_TX_CHECK_EN adds column-range checking
module smvm_stream_tx #(
    parameter int K          = 4,
    parameter int GAP_CYCLES = 8
) (
    input logic             clk,
    input logic             rst_n,
    smvm_stream_tx_if.slave bus
);
    localparam int EW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = $clog2(K + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ROWS, S_COLS, S_VEC, S_NZ, S_END, S_GAP} state_t;

    state_t          state, state_nxt;
    logic [11:0]     rows_q, cols_q;
    logic [12:0]     vec_n, vec_cnt;
    logic            cur, wr, last_seen, ph;
    logic [CW-1:0]   cnt      [2];
    logic            grp_last [2];
    logic [7:0]      bval     [2][K];
    logic            bipv     [2][K];
    logic [11:0]     bcol     [2][K];
    logic [EW-1:0]   ent, wr_idx;
    logic [GW-1:0]   gap_cnt;
    logic            hdr_acc, nz_acc, nz_window, ent_valid, grp_done, valid_d;
    logic [11:0]     word_d;

    // cur is the group being emitted; the other buffer always takes new nonzeros
    assign wr        = ~cur;
    assign wr_idx    = cnt[wr][EW-1:0];
    assign vec_n     = (cols_q == 12'd0) ? 13'd4096 : {1'b0, cols_q};
    assign nz_window = (state == S_FILL) || (state == S_ROWS) || (state == S_COLS) ||
                       (state == S_VEC)  || (state == S_NZ);
    assign ent_valid = CW'(ent) < cnt[cur];
    assign grp_done  = (state == S_NZ) && ph && (ent == EW'(K - 1));

    assign bus.hdr_ready = rst_n & (state == S_IDLE);
    assign bus.vec_ready = (state == S_VEC);
    assign bus.nz_ready  = nz_window & ~last_seen & (cnt[wr] < CW'(K));
    assign bus.busy      = (state != S_IDLE);
    assign hdr_acc       = bus.hdr_valid & bus.hdr_ready;
    assign nz_acc        = bus.nz_valid & bus.nz_ready;

    always_comb begin
        state_nxt = state;
        valid_d   = 1'b0;
        word_d    = 12'd0;
        case (state)
            S_IDLE: if (hdr_acc) state_nxt = S_FILL;
            S_FILL: if (nz_acc && (bus.nz_last || cnt[wr] == CW'(K - 1))) state_nxt = S_ROWS;
            S_ROWS: begin
                valid_d   = 1'b1;
                word_d    = rows_q;
                state_nxt = S_COLS;
            end
            S_COLS: begin
                valid_d   = 1'b1;
                word_d    = cols_q;
                state_nxt = S_VEC;
            end
            S_VEC: begin
                valid_d = 1'b1;
                if (bus.vec_valid) word_d = {bus.vec_data, 4'b0000};
                if (vec_cnt == vec_n - 13'd1) state_nxt = S_NZ;
            end
            S_NZ: begin
                valid_d = 1'b1;
                if (ent_valid) word_d = ph ? bcol[cur][ent] : {bval[cur][ent], bipv[cur][ent], 3'b000};
                if (grp_done && grp_last[cur]) state_nxt = S_END;
            end
            S_END: state_nxt = S_GAP;
            S_GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            bus.tx_valid <= 1'b0;
            bus.tx_val   <= 8'd0;
            bus.tx_ipv   <= 1'b0;
            bus.tx_col   <= 3'd0;
        end else begin
            state        <= state_nxt;
            bus.tx_valid <= valid_d;
            bus.tx_val   <= word_d[11:4];
            bus.tx_ipv   <= word_d[3];
            bus.tx_col   <= word_d[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q           <= 12'd0;
            cols_q           <= 12'd0;
            vec_cnt          <= 13'd0;
            cur              <= 1'b0;
            last_seen        <= 1'b0;
            ph               <= 1'b0;
            ent              <= '0;
            gap_cnt          <= '0;
            bus.err_underrun <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                cnt[b]      <= '0;
                grp_last[b] <= 1'b0;
                for (int i = 0; i < K; i++) begin
                    bval[b][i] <= 8'd0;
                    bipv[b][i] <= 1'b0;
                    bcol[b][i] <= 12'd0;
                end
            end
        end else begin
            if (hdr_acc) begin
                rows_q           <= bus.hdr_rows;
                cols_q           <= bus.hdr_cols;
                vec_cnt          <= 13'd0;
                cur              <= 1'b1;
                last_seen        <= 1'b0;
                ph               <= 1'b0;
                ent              <= '0;
                bus.err_underrun <= 1'b0;
                for (int b = 0; b < 2; b++) begin
                    cnt[b]      <= '0;
                    grp_last[b] <= 1'b0;
                end
            end
            if (state == S_FILL && state_nxt == S_ROWS) cur <= 1'b0;
            if (state == S_VEC) begin
                vec_cnt <= vec_cnt + 13'd1;
                if (!bus.vec_valid) bus.err_underrun <= 1'b1;
            end
            if (state == S_NZ) begin
                ph <= ~ph;
                if (ph) ent <= (ent == EW'(K - 1)) ? '0 : ent + 1'b1;
                // padding inside a group that does not hold nz_last means the host fell behind
                if (!ph && !ent_valid && !grp_last[cur]) bus.err_underrun <= 1'b1;
            end
            if (grp_done && !grp_last[cur]) begin
                cur           <= ~cur;
                cnt[cur]      <= '0;
                grp_last[cur] <= 1'b0;
            end
            if (nz_acc) begin
                bval[wr][wr_idx] <= bus.nz_val;
                bipv[wr][wr_idx] <= bus.nz_ipv;
                bcol[wr][wr_idx] <= bus.nz_col;
                cnt[wr]          <= cnt[wr] + 1'b1;
                if (bus.nz_last) begin
                    grp_last[wr] <= 1'b1;
                    last_seen    <= 1'b1;
                end
            end
            if (state == S_END)      gap_cnt <= '0;
            else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
        end
    end

`ifdef SMVM_TX_CHECK_EN
    logic err_col_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      err_col_q <= 1'b0;
        else if (hdr_acc)                                err_col_q <= 1'b0;
        else if (nz_acc && {1'b0, bus.nz_col} >= vec_n) err_col_q <= 1'b1;
    end
    assign bus.err_col = err_col_q;
`else
    assign bus.err_col = 1'b0;
`endif
endmodule
